// File: rtl/clk_ratio_checker_pkg.sv
// rtl/clk_ratio_checker_pkg.sv - shared state encoding and default divider ratios
package clk_ratio_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int DEF_HALF_4F  = 2;
    localparam int DEF_HALF_2F  = 4;
    localparam int DEF_HALF_F   = 8;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_LOCK_CNT = 4;

endpackage

// File: rtl/clk_ratio_checker_if.sv
// rtl/clk_ratio_checker_if.sv - monitored clocks, clear pulse and lock/error status
interface clk_ratio_checker_if;

    logic       clk4f;
    logic       clk2f;
    logic       clkf;
    logic       err_clr;
    logic       locked;
    logic       err_4f;
    logic       err_2f;
    logic       err_f;
    logic       err_phase;
    logic [1:0] state;

    modport master (
        output clk4f, clk2f, clkf, err_clr,
        input  locked, err_4f, err_2f, err_f, err_phase, state
    );

    modport slave (
        input  clk4f, clk2f, clkf, err_clr,
        output locked, err_4f, err_2f, err_f, err_phase, state
    );

endinterface

// File: rtl/clk_half_period_mon.sv
// rtl/clk_half_period_mon.sv - samples one divided clock and judges each half-period length
module clk_half_period_mon #(
    parameter int HALF  = 2,
    parameter int CNT_W = 4
) (
    input  logic clk16f,
    input  logic reset,
    input  logic clr,
    input  logic clk_in,
    output logic toggle,
    output logic armed,
    output logic period_err
);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);

    logic             r_q, r_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arm_q, arm_d;

    assign toggle = r_q ^ r_dly_q;
    assign armed  = arm_q;
    assign cnt_d  = toggle ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    assign arm_d  = clr ? 1'b0 : (arm_q | toggle);

    // A missing edge fires exactly once: cnt only equals HALF for one cycle before moving past it.
    assign period_err = arm_q & (toggle ? (cnt_q != HALF_C) : (cnt_q == HALF_C));

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            r_q     <= 1'b1;
            r_dly_q <= 1'b1;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            r_q     <= clk_in;
            r_dly_q <= r_q;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
        end
    end

endmodule

// File: rtl/clk_ratio_checker.sv
// rtl/clk_ratio_checker.sv - lock/acquire FSM over clk4f/clk2f/clkf ratio and phase checks
module clk_ratio_checker
    import clk_ratio_checker_pkg::*;
#(
    parameter int HALF_4F  = DEF_HALF_4F,
    parameter int HALF_2F  = DEF_HALF_2F,
    parameter int HALF_F   = DEF_HALF_F,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                  clk16f,
    input  logic                  reset,
    clk_ratio_checker_if.slave    bus
);

    localparam int              GW     = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]   LOCK_C = GW'(LOCK_CNT);

    state_t        state_q;
    logic          locked_q;
    logic [GW-1:0] good_q;
    logic          err_4f_q, err_2f_q, err_f_q, err_ph_q;

    logic t4, a4, pe4, t2, a2, pe2, tf, af, pef;
    logic clr_w, ph_err, any_err, good_tick;

    assign clr_w = bus.err_clr & (state_q != ST_IDLE);

    clk_half_period_mon #(.HALF(HALF_4F), .CNT_W(CNT_W)) u_mon_4f (
        .clk16f(clk16f), .reset(reset), .clr(clr_w), .clk_in(bus.clk4f),
        .toggle(t4), .armed(a4), .period_err(pe4)
    );

    clk_half_period_mon #(.HALF(HALF_2F), .CNT_W(CNT_W)) u_mon_2f (
        .clk16f(clk16f), .reset(reset), .clr(clr_w), .clk_in(bus.clk2f),
        .toggle(t2), .armed(a2), .period_err(pe2)
    );

    clk_half_period_mon #(.HALF(HALF_F), .CNT_W(CNT_W)) u_mon_f (
        .clk16f(clk16f), .reset(reset), .clr(clr_w), .clk_in(bus.clkf),
        .toggle(tf), .armed(af), .period_err(pef)
    );

    // An edge that is already a period error of its own channel is not reported again as misalignment.
    assign ph_err    = (t2 & ~t4 & a2 & a4 & ~pe2) | (tf & ~t2 & af & a2 & ~pef);
    assign any_err   = pe4 | pe2 | pef | ph_err;
    assign good_tick = tf & af & ~any_err;

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            good_q   <= '0;
            err_4f_q <= 1'b0;
            err_2f_q <= 1'b0;
            err_f_q  <= 1'b0;
            err_ph_q <= 1'b0;
        end else if (clr_w) begin
            state_q  <= ST_ACQUIRE;
            locked_q <= 1'b0;
            good_q   <= '0;
            err_4f_q <= 1'b0;
            err_2f_q <= 1'b0;
            err_f_q  <= 1'b0;
            err_ph_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tf) state_q <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (any_err) begin
                        good_q <= '0;
                    end else if (good_tick) begin
                        good_q <= good_q + GW'(1);
                        if (good_q == LOCK_C - GW'(1)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                ST_LOCKED, ST_ERROR: begin
                    err_4f_q <= err_4f_q | pe4;
                    err_2f_q <= err_2f_q | pe2;
                    err_f_q  <= err_f_q  | pef;
                    err_ph_q <= err_ph_q | ph_err;
                    if (any_err) begin
                        state_q  <= ST_ERROR;
                        locked_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.locked    = locked_q;
    assign bus.state     = state_q;
    assign bus.err_4f    = err_4f_q;
    assign bus.err_2f    = err_2f_q;
    assign bus.err_f     = err_f_q;
    assign bus.err_phase = err_ph_q;

endmodule
